// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Latched request type; a store wins when both strobes are set.
    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // Ceiling log2 for elaboration-time widths (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH x 32, synchronous write, registered read-before-write.
// Latency: read data appears one clock after re_i; writes land on the same edge.
// Backpressure: none; every enabled access completes on the edge it is presented.
module dmem_array #(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic             re_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdat_i,
    output logic [31:0]      rdat_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdat_q;

    // Storage is deliberately left out of reset so it survives a CPU reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdat_i;
        end
    end

    // Read register samples the pre-write word; clear wins for rejected accesses.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
        end else if (clr_i) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[idx_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target with a fixed service time; optional DMEM_ALIGN_CHECK_EN adds err_o.
// Latency: ready_o pulses LATENCY cycles after the IDLE acceptance cycle; data_o valid with it.
// Backpressure: stall_o holds the pipeline from acceptance until the DONE cycle; no new accept in DONE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ready_o
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        err_o
`endif
);

    localparam int         IDX_W    = clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               typ_q, typ_d;
    logic               rd_q, rd_d;
    logic               bad_q, bad_d;
    logic               ready_q;
    logic               err_q;

    logic               req;
    logic               addr_bad;
    logic               fire;
    logic               arr_we;
    logic               arr_re;
    logic               arr_clr;

    assign req = MemRead_i | MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned or beyond the array: completes normally but is flagged and has no effect.
    assign addr_bad = (addr_i[1:0] != 2'b00) || (addr_i[31:IDX_W+2] != '0);
`else
    // Without checking, low bits are dropped and the index wraps modulo DEPTH.
    assign addr_bad = 1'b0;
`endif

    // Bits that never reach the index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:IDX_W+2]};

    // Next-state logic; *_d carries the transaction seen on the completion edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        typ_d   = typ_q;
        rd_d    = rd_q;
        bad_d   = bad_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d  = addr_i[IDX_W+1:2];
                    wdat_d = data_i;
                    typ_d  = MemWrite_i ? REQ_WR : REQ_RD;
                    rd_d   = MemRead_i;
                    bad_d  = addr_bad;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        fire    = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                // Inputs are ignored here; the latched request always finishes.
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gate with rst_n so a request held during reset can never commit.
    assign arr_we  = fire & rst_n & (typ_d == REQ_WR) & ~bad_d;
    assign arr_re  = fire & rst_n & rd_d & ~bad_d;
    assign arr_clr = fire & rst_n & bad_d;

    // FSM, request latch and completion flags.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdat_q  <= '0;
            typ_q   <= REQ_RD;
            rd_q    <= 1'b0;
            bad_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            typ_q   <= typ_d;
            rd_q    <= rd_d;
            bad_q   <= bad_d;
            ready_q <= fire;
            err_q   <= fire & bad_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .clr_i  (arr_clr),
        .idx_i  (idx_d),
        .wdat_i (wdat_d),
        .rdat_o (data_o)
    );

    assign stall_o = ((state_q == IDLE) & req) | (state_q == BUSY);
    assign ready_o = ready_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule
